// File: rtl/y86_pkg.sv
// Shared Y86 encodings and pipeline-controller state type.
package y86_pkg;

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE    = 4'hF;

  localparam logic [1:0] S_AOK    = 2'd0;

  typedef enum logic [1:0] {StRun, StPause, StHalt} state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipe_control_unit.sv
// Y86 pipeline controller: hazard detection, stall/bubble generation, run/pause/step/halt
// sequencing and saturating performance counters.
module pipe_control_unit
  import y86_pkg::*;
#(
  parameter int unsigned CNT_W     = 32,
  parameter bit          START_RUN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [1:0]       m_status,
  input  logic [3:0]       W_icode,
  input  logic [1:0]       W_status,
  input  logic             run_en,
  input  logic             step_req,
  input  logic             clr_cnt,
  output logic             F_stall,
  output logic             D_stall,
  output logic             E_stall,
  output logic             M_stall,
  output logic             W_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             set_cc_en,
  output logic             halted,
  output logic [1:0]       halt_status,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mp_cnt
);

  state_e state_q;

  logic lu, rt, mp, xm, xw, adv;

  assign lu = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != RNONE) &&
              ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign rt = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
  assign mp = (E_icode == I_JXX) && !e_Cnd;
  assign xm = (m_status != S_AOK);
  assign xw = (W_status != S_AOK);

  // Gating with rst_n keeps the pipeline frozen while reset is held, even when leaving into RUN.
  assign adv = rst_n && ((state_q == StRun) || ((state_q == StPause) && step_req));

  always_comb begin
    F_stall   = 1'b1;
    D_stall   = 1'b1;
    E_stall   = 1'b1;
    M_stall   = 1'b1;
    W_stall   = 1'b1;
    D_bubble  = 1'b0;
    E_bubble  = 1'b0;
    M_bubble  = 1'b0;
    set_cc_en = 1'b0;
    if (adv) begin
      F_stall   = lu || rt;
      D_stall   = lu;
      E_stall   = 1'b0;
      M_stall   = 1'b0;
      W_stall   = xw;
      D_bubble  = mp || (rt && !lu);
      E_bubble  = mp || lu;
      M_bubble  = xm || xw;
      set_cc_en = (E_icode == I_OPQ) && !xm && !xw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= START_RUN ? StRun : StPause;
      halt_status <= 2'd0;
      halted      <= 1'b0;
    end else if (state_q != StHalt) begin
      if (adv && xw) begin
        state_q     <= StHalt;
        halt_status <= W_status;
        halted      <= 1'b1;
      end else begin
        state_q <= run_en ? StRun : StPause;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_cyc_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_cnt),
    .inc   (adv),
    .q     (cyc_cnt)
  );

  sat_counter #(.W(CNT_W)) u_ret_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_cnt),
    .inc   (adv && (W_status == S_AOK) && (W_icode != I_NOP)),
    .q     (ret_cnt)
  );

  sat_counter #(.W(CNT_W)) u_lu_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_cnt),
    .inc   (adv && lu),
    .q     (lu_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mp_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_cnt),
    .inc   (adv && mp),
    .q     (mp_cnt)
  );

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed bench for pipe_control_unit: a 4-bit-counter instance leaving reset in RUN and a
// 32-bit instance leaving reset in PAUSE share all inputs.
module tb_pipe_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] D_icode, E_icode, E_dstM, d_srcA, d_srcB, M_icode, W_icode;
  logic       e_Cnd, run_en, step_req, clr_cnt;
  logic [1:0] m_status, W_status;

  logic       F_stall, D_stall, E_stall, M_stall, W_stall;
  logic       D_bubble, E_bubble, M_bubble, set_cc_en, halted;
  logic [1:0] halt_status;
  logic [3:0] cyc_cnt, ret_cnt, lu_cnt, mp_cnt;

  logic        p_F_stall, p_D_stall, p_E_stall, p_M_stall, p_W_stall;
  logic        p_D_bubble, p_E_bubble, p_M_bubble, p_set_cc_en, p_halted;
  logic [1:0]  p_halt_status;
  logic [31:0] p_cyc_cnt, p_ret_cnt, p_lu_cnt, p_mp_cnt;

  int checks = 0;
  int errors = 0;

  logic [4:0] stalls, p_stalls;
  logic [2:0] bubbles;
  assign stalls   = {F_stall, D_stall, E_stall, M_stall, W_stall};
  assign p_stalls = {p_F_stall, p_D_stall, p_E_stall, p_M_stall, p_W_stall};
  assign bubbles  = {D_bubble, E_bubble, M_bubble};

  always #5 clk = ~clk;

  pipe_control_unit #(.CNT_W(4), .START_RUN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .E_icode(E_icode), .E_dstM(E_dstM),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .e_Cnd(e_Cnd), .M_icode(M_icode), .m_status(m_status),
    .W_icode(W_icode), .W_status(W_status), .run_en(run_en), .step_req(step_req),
    .clr_cnt(clr_cnt), .F_stall(F_stall), .D_stall(D_stall), .E_stall(E_stall),
    .M_stall(M_stall), .W_stall(W_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .M_bubble(M_bubble), .set_cc_en(set_cc_en), .halted(halted), .halt_status(halt_status),
    .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .lu_cnt(lu_cnt), .mp_cnt(mp_cnt)
  );

  pipe_control_unit #(.CNT_W(32), .START_RUN(1'b0)) u_pause (
    .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .E_icode(E_icode), .E_dstM(E_dstM),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .e_Cnd(e_Cnd), .M_icode(M_icode), .m_status(m_status),
    .W_icode(W_icode), .W_status(W_status), .run_en(run_en), .step_req(step_req),
    .clr_cnt(clr_cnt), .F_stall(p_F_stall), .D_stall(p_D_stall), .E_stall(p_E_stall),
    .M_stall(p_M_stall), .W_stall(p_W_stall), .D_bubble(p_D_bubble), .E_bubble(p_E_bubble),
    .M_bubble(p_M_bubble), .set_cc_en(p_set_cc_en), .halted(p_halted),
    .halt_status(p_halt_status), .cyc_cnt(p_cyc_cnt), .ret_cnt(p_ret_cnt),
    .lu_cnt(p_lu_cnt), .mp_cnt(p_mp_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic defaults();
    D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
    E_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF; e_Cnd = 1'b1;
    m_status = 2'd0; W_status = 2'd0;
    run_en = 1'b1; step_req = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic clear_counters();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    defaults();
    #3;
    chk("reset_stalls", 32'(stalls), 32'h1F);
    chk("reset_bubbles", 32'({bubbles, set_cc_en}), 32'h0);
    chk("reset_cyc", 32'(cyc_cnt), 32'h0);
    chk("reset_halted", 32'({halted, halt_status}), 32'h0);
    chk("reset_p_stalls", 32'(p_stalls), 32'h1F);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("run_no_hazard_stalls", 32'(stalls), 32'h00);
    chk("run_no_hazard_bubbles", 32'(bubbles), 32'h0);
    chk("pause_after_reset_stalls", 32'(p_stalls), 32'h1F);
    tick();
    chk("first_cyc", 32'(cyc_cnt), 32'h1);
    chk("pause_cyc_frozen", p_cyc_cnt, 32'h0);

    // Load/use via srcA, then srcB, then a POPQ with no destination.
    clear_counters();
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    #1;
    chk("lu_stalls", 32'(stalls), 32'h18);
    chk("lu_bubbles", 32'(bubbles), 32'h2);
    tick();
    chk("lu_cnt", 32'(lu_cnt), 32'h1);
    chk("lu_cyc", 32'(cyc_cnt), 32'h1);
    defaults();
    E_icode = 4'hB; E_dstM = 4'h2; d_srcB = 4'h2;
    #1;
    chk("lu_srcb_stalls", 32'(stalls), 32'h18);
    E_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF;
    #1;
    chk("lu_rnone_stalls", 32'(stalls), 32'h00);
    chk("lu_rnone_bubbles", 32'(bubbles), 32'h0);

    // Ret hazards, alone and combined with load/use.
    defaults();
    D_icode = 4'h9;
    #1;
    chk("ret_d_stalls", 32'(stalls), 32'h10);
    chk("ret_d_bubbles", 32'(bubbles), 32'h4);
    E_icode = 4'h5; E_dstM = 4'h4; d_srcA = 4'h4;
    #1;
    chk("ret_lu_stalls", 32'(stalls), 32'h18);
    chk("ret_lu_bubbles", 32'(bubbles), 32'h2);
    defaults();
    M_icode = 4'h9;
    #1;
    chk("ret_m_bubbles", 32'(bubbles), 32'h4);

    // Mispredict and correctly predicted jump.
    defaults();
    clear_counters();
    E_icode = 4'h7; e_Cnd = 1'b0;
    #1;
    chk("mp_stalls", 32'(stalls), 32'h00);
    chk("mp_bubbles", 32'(bubbles), 32'h6);
    tick();
    chk("mp_cnt", 32'(mp_cnt), 32'h1);
    e_Cnd = 1'b1;
    #1;
    chk("jxx_taken_bubbles", 32'(bubbles), 32'h0);
    tick();
    chk("jxx_taken_mp_cnt", 32'(mp_cnt), 32'h1);

    // Exception in M then W: halt and freeze.
    defaults();
    clear_counters();
    E_icode = 4'h6;
    #1;
    chk("opq_cc", 32'(set_cc_en), 32'h1);
    m_status = 2'd2;
    #1;
    chk("xm_cc", 32'(set_cc_en), 32'h0);
    chk("xm_bubbles", 32'(bubbles), 32'h1);
    chk("xm_stalls", 32'(stalls), 32'h00);
    tick();
    m_status = 2'd0; W_status = 2'd2;
    #1;
    chk("xw_stalls", 32'(stalls), 32'h01);
    chk("xw_bubbles_cc", 32'({bubbles, set_cc_en}), 32'h2);
    chk("xw_not_yet_halted", 32'(halted), 32'h0);
    tick();
    chk("halted", 32'(halted), 32'h1);
    chk("halt_status", 32'(halt_status), 32'h2);
    chk("halt_cyc", 32'(cyc_cnt), 32'h2);
    W_status = 2'd0; E_icode = 4'h5; E_dstM = 4'h1; d_srcA = 4'h1; step_req = 1'b1;
    #1;
    chk("halt_stalls", 32'(stalls), 32'h1F);
    chk("halt_bubbles_cc", 32'({bubbles, set_cc_en}), 32'h0);
    repeat (3) tick();
    chk("halt_cyc_frozen", 32'(cyc_cnt), 32'h2);
    chk("halt_lu_frozen", 32'(lu_cnt), 32'h0);
    chk("halt_absorbing", 32'({halted, halt_status}), 32'h6);
    rst_n = 1'b0;
    #1;
    chk("halt_reset_halted", 32'({halted, halt_status}), 32'h0);
    chk("halt_reset_cyc", 32'(cyc_cnt), 32'h0);
    chk("halt_reset_stalls", 32'(stalls), 32'h1F);
    defaults();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("after_halt_reset_run", 32'(stalls), 32'h00);

    // Pause with a single step, then step-into-run.
    clear_counters();
    run_en = 1'b0;
    tick();
    chk("pause_entry_cyc", 32'(cyc_cnt), 32'h1);
    chk("paused_stalls", 32'(stalls), 32'h1F);
    tick();
    step_req = 1'b1;
    #1;
    chk("step_stalls", 32'(stalls), 32'h00);
    tick();
    step_req = 1'b0;
    #1;
    chk("post_step_stalls", 32'(stalls), 32'h1F);
    tick();
    tick();
    chk("pause_step_cyc", 32'(cyc_cnt), 32'h2);
    run_en = 1'b1; step_req = 1'b1;
    #1;
    chk("step_to_run_stalls", 32'(stalls), 32'h00);
    tick();
    step_req = 1'b0;
    #1;
    chk("step_to_run_state", 32'(stalls), 32'h00);
    tick();
    chk("step_to_run_cyc", 32'(cyc_cnt), 32'h4);

    // Saturation of 4-bit counters, clear priority, asynchronous reset mid-run.
    clear_counters();
    W_icode = 4'h6;
    repeat (20) tick();
    chk("sat_cyc", 32'(cyc_cnt), 32'hF);
    chk("sat_ret", 32'(ret_cnt), 32'hF);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_priority_cyc", 32'(cyc_cnt), 32'h0);
    chk("clr_priority_ret", 32'(ret_cnt), 32'h0);
    tick();
    chk("after_clr_ret", 32'(ret_cnt), 32'h1);
    W_icode = 4'h1;
    tick();
    chk("nop_no_ret", 32'({cyc_cnt, ret_cnt}), 32'h21);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_cnt", 32'({cyc_cnt, ret_cnt}), 32'h00);
    chk("async_reset_stalls", 32'(stalls), 32'h1F);
    chk("async_reset_p_cyc", p_cyc_cnt, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
